// File: rtl/fnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fnt_pkg
// Description : Shared encodings, sizes and modular add/sub helpers for the
//               Fermat-number-transform butterfly (modulus M = 2^N+1).
// Revision    : 1.0 - initial release
// ============================================================================
package fnt_pkg;

  // Butterfly mode encodings
  localparam logic FNT_DIF = 1'b0;
  localparam logic FNT_DIT = 1'b1;

  // Default modulus exponent and residue width (residues span [0, 2^N])
  localparam int FNT_N  = 16;
  localparam int FNT_DW = FNT_N + 1;

  // Wide carrier type so the helpers work for any N up to 62
  typedef logic [63:0] fnt_word_t;

  // Modulus M = 2^n + 1
  function automatic fnt_word_t fnt_mod(input int n);
    return (fnt_word_t'(1) << n) + fnt_word_t'(1);
  endfunction

  // (a + b) mod m for canonical a, b
  function automatic fnt_word_t fnt_add_mod(input fnt_word_t a, input fnt_word_t b,
                                            input fnt_word_t m);
    fnt_word_t sum;
    sum = a + b;
    if (sum >= m) sum = sum - m;
    return sum;
  endfunction

  // (a - b) mod m for canonical a, b; a negative difference wraps by adding m
  function automatic fnt_word_t fnt_sub_mod(input fnt_word_t a, input fnt_word_t b,
                                            input fnt_word_t m);
    fnt_word_t diff;
    if (a >= b) diff = a - b;
    else        diff = a + m - b;
    return diff;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fnt_shift_reduce.sv
`default_nettype none
// ============================================================================
// Module      : fnt_shift_reduce
// Description : One lane of y = x * 2^s mod (2^N+1). Stage A reduces the
//               exponent and splits the shifted value into low/high halves;
//               stage B folds them (L - H), corrects once and applies the
//               sign flip for exponents >= N. Output is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module fnt_shift_reduce
  import fnt_pkg::*;
#(
  parameter int N  = 16,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N:0]    x,
  input  logic [SW-1:0] s,
  output logic [N:0]    y
);

  localparam int DW = N + 1;
  localparam int PW = 2 * N + 1;
  localparam logic [SW:0]  c_two_n = (SW + 1)'(2 * N);
  localparam logic [SW:0]  c_n     = (SW + 1)'(N);
  localparam logic [N+1:0] c_m_ext = (N + 2)'(fnt_mod(N));
  localparam logic [N:0]   c_m     = DW'(fnt_mod(N));

  logic [SW:0]   w_smod;
  logic          w_neg;
  logic [SW:0]   w_t;
  logic [PW-1:0] w_prod;

  logic [N-1:0]  r_lo;
  logic [N:0]    r_hi;
  logic          r_neg;

  logic [N+1:0]  w_diff;
  logic [N:0]    w_r;
  logic [N:0]    w_y;
  logic [N:0]    r_y;

  // Exponent reduction: 2^N == -1, so s' >= N becomes 2^(s'-N) plus a negation
  always_comb begin
    w_smod = {1'b0, s} % c_two_n;
    w_neg  = (w_smod >= c_n);
    w_t    = w_neg ? (w_smod - c_n) : w_smod;
    w_prod = PW'(x) << w_t;
  end

  // Stage A register: low N bits, high bits and pending negation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lo  <= '0;
      r_hi  <= '0;
      r_neg <= 1'b0;
    end else if (en) begin
      r_lo  <= w_prod[N-1:0];
      r_hi  <= w_prod[PW-1:N];
      r_neg <= w_neg;
    end
  end

  // Fold L - H with a single +M / -M correction, then negate if required
  always_comb begin
    w_diff = {2'b00, r_lo} - {1'b0, r_hi};
    if (w_diff[N+1])            w_r = DW'(w_diff + c_m_ext);
    else if (w_diff >= c_m_ext) w_r = DW'(w_diff - c_m_ext);
    else                        w_r = DW'(w_diff);
    if (r_neg && (w_r != '0))   w_y = c_m - w_r;
    else                        w_y = w_r;
  end

  // Stage B register: canonical product
  always_ff @(posedge clk) begin
    if (!rst_n)  r_y <= '0;
    else if (en) r_y <= w_y;
  end

  assign y = r_y;

endmodule
`default_nettype wire

// File: rtl/fnt_butterfly_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fnt_butterfly_pipe
// Description : Three-stage, multi-lane radix-2 FNT butterfly with power-of-
//               two twiddles, DIF/DIT per beat, valid/ready handshake.
//               DIF: add/sub -> shift+split -> correction.
//               DIT: shift+split -> correction -> add/sub.
//               Each lane carries one shifter at the front (DIT) and one at
//               the back (DIF) so mixed-mode beats can stream back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module fnt_butterfly_pipe
  import fnt_pkg::*;
#(
  parameter int N     = FNT_N,
  parameter int LANES = 4,
  parameter int SW    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [SW-1:0]            in_shift,
  input  logic [LANES*(N+1)-1:0]   in_a,
  input  logic [LANES*(N+1)-1:0]   in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*(N+1)-1:0]   out_a,
  output logic [LANES*(N+1)-1:0]   out_b
);

  localparam int        DW  = N + 1;
  localparam fnt_word_t c_m = fnt_mod(N);

  logic          w_adv;
  logic          w_fire;
  logic          r_v1, r_v2, r_v3;
  logic          r_mode1, r_mode2, r_mode3;
  logic [SW-1:0] r_s1;

  // Whole pipe moves together; a full output that is not taken freezes it
  assign w_adv     = out_ready | ~r_v3;
  assign w_fire    = in_valid & w_adv;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;

  // Stage valids plus the mode/shift that travel alongside the data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_mode1 <= FNT_DIF;
      r_mode2 <= FNT_DIF;
      r_mode3 <= FNT_DIF;
      r_s1    <= '0;
    end else if (w_adv) begin
      r_v1    <= in_valid;
      r_v2    <= r_v1;
      r_v3    <= r_v2;
      if (w_fire) begin
        r_mode1 <= in_mode;
        r_s1    <= in_shift;
      end
      r_mode2 <= r_mode1;
      r_mode3 <= r_mode2;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] w_a_in;
    logic [DW-1:0] w_b_in;
    logic [DW-1:0] w_t_dit;
    logic [DW-1:0] w_b_dif;
    logic [DW-1:0] r1_a;
    logic [DW-1:0] r1_b;
    logic [DW-1:0] r2_a;
    logic [DW-1:0] r3_a;
    logic [DW-1:0] r3_b;

    assign w_a_in = in_a[k*DW +: DW];
    assign w_b_in = in_b[k*DW +: DW];

    // DIT twiddle product t = b * 2^s, ready at stage 2
    fnt_shift_reduce #(
      .N  (N),
      .SW (SW)
    ) u_shift_dit (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_adv),
      .x     (w_b_in),
      .s     (in_shift),
      .y     (w_t_dit)
    );

    // DIF twiddle product (a - b) * 2^s, ready at stage 3
    fnt_shift_reduce #(
      .N  (N),
      .SW (SW)
    ) u_shift_dif (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_adv),
      .x     (r1_b),
      .s     (r_s1),
      .y     (w_b_dif)
    );

    // Stage 1: DIF sum/difference, or pass a through for DIT
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r1_a <= '0;
        r1_b <= '0;
      end else if (w_fire) begin
        if (in_mode == FNT_DIF) begin
          r1_a <= DW'(fnt_add_mod(fnt_word_t'(w_a_in), fnt_word_t'(w_b_in), c_m));
          r1_b <= DW'(fnt_sub_mod(fnt_word_t'(w_a_in), fnt_word_t'(w_b_in), c_m));
        end else begin
          r1_a <= w_a_in;
          r1_b <= '0;
        end
      end
    end

    // Stage 2 carries a (DIF sum or DIT operand); stage 3 finishes DIT add/sub
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r2_a <= '0;
        r3_a <= '0;
        r3_b <= '0;
      end else if (w_adv) begin
        r2_a <= r1_a;
        if (r_mode2 == FNT_DIT) begin
          r3_a <= DW'(fnt_add_mod(fnt_word_t'(r2_a), fnt_word_t'(w_t_dit), c_m));
          r3_b <= DW'(fnt_sub_mod(fnt_word_t'(r2_a), fnt_word_t'(w_t_dit), c_m));
        end else begin
          r3_a <= r2_a;
          r3_b <= '0;
        end
      end
    end

    assign out_a[k*DW +: DW] = r3_a;
    assign out_b[k*DW +: DW] = (r_mode3 == FNT_DIT) ? r3_b : w_b_dif;
  end

endmodule
`default_nettype wire

// File: tb/tb_fnt_butterfly_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fnt_butterfly_pipe
// Description : Self-checking bench for fnt_butterfly_pipe: plain modular-
//               arithmetic reference model, scoreboard queue, directed
//               boundary beats, streaming, backpressure, reset and a random
//               sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fnt_butterfly_pipe;
  import fnt_pkg::*;

  localparam int     N     = FNT_N;
  localparam int     LANES = 4;
  localparam int     SW    = 5;
  localparam int     DW    = FNT_DW;
  localparam int     BW    = LANES * DW;
  localparam longint M     = 65537;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [SW-1:0] in_shift = '0;
  logic [BW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_a;
  logic [BW-1:0] out_b;

  always #5 clk = ~clk;

  fnt_butterfly_pipe #(
    .N     (N),
    .LANES (LANES),
    .SW    (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_shift  (in_shift),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  typedef struct {
    logic [BW-1:0] ea;
    logic [BW-1:0] eb;
  } exp_t;

  exp_t   q[$];
  int     rx_cyc[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_sent   = 0;
  int     n_recv   = 0;
  int     n_disc   = 0;
  int     cyc      = 0;
  bit     rand_ready = 1'b0;
  bit     prev_stall = 1'b0;
  logic [BW-1:0] prev_a, prev_b;
  exp_t   e_mon;
  longint ra_mon, rb_mon;

  // 2^s mod M by repeated doubling
  function automatic longint pow2mod(input int s);
    longint w;
    w = 1;
    for (int i = 0; i < (s % (2 * N)); i++) w = (w * 2) % M;
    return w;
  endfunction

  // Reference butterfly straight from the modular definitions
  task automatic bfly(input logic mode, input int s, input longint a, input longint b,
                      output longint ra, output longint rb);
    longint w, t;
    w = pow2mod(s);
    if (mode == FNT_DIF) begin
      ra = (a + b) % M;
      rb = ((((a - b) % M) + M) % M * w) % M;
    end else begin
      t  = (b * w) % M;
      ra = (a + t) % M;
      rb = (((a - t) % M) + M) % M;
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint rand_op();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return M - 1;
      2:       return M - 2;
      3:       return 1;
      default: return longint'($urandom_range(0, 65536));
    endcase
  endfunction

  task automatic rand_bus(output logic [BW-1:0] va, output logic [BW-1:0] vb);
    for (int k = 0; k < LANES; k++) begin
      va[k*DW +: DW] = DW'(rand_op());
      vb[k*DW +: DW] = DW'(rand_op());
    end
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic drive(input logic mode, input int s, input logic [BW-1:0] va,
                       input logic [BW-1:0] vb, output int waits);
    logic acc;
    in_valid = 1'b1;
    in_mode  = mode;
    in_shift = SW'(s);
    in_a     = va;
    in_b     = vb;
    waits    = 0;
    acc      = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      waits++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waits);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain outstanding beats", q.size(), 0);
  endtask

  // Single isolated beat: exact latency plus literal lane-0 results
  task automatic directed(input string name, input logic mode, input int s,
                          input longint a0, input longint b0,
                          input longint ea, input longint eb);
    logic [BW-1:0] va, vb;
    int w;
    rand_bus(va, vb);
    va[DW-1:0] = DW'(a0);
    vb[DW-1:0] = DW'(b0);
    drive(mode, s, va, vb, w);
    @(negedge clk); check({name, " out_valid +1"}, out_valid, 0);
    @(negedge clk); check({name, " out_valid +2"}, out_valid, 0);
    @(negedge clk); check({name, " out_valid +3"}, out_valid, 1);
    check({name, " a'"}, longint'(out_a[DW-1:0]), ea);
    check({name, " b'"}, longint'(out_b[DW-1:0]), eb);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted beats, compare delivered beats, watch holds
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      n_disc += q.size();
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_a !== prev_a || out_b !== prev_b) begin
          n_fail++;
          $display("FAIL output hold: out_valid=%b out_a=%h out_b=%h, expected held 1 %h %h",
                   out_valid, out_a, out_b, prev_a, prev_b);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL stray beat: out_valid=1 out_a=%h, expected no beat", out_a);
        end else begin
          e_mon = q.pop_front();
          if (out_a !== e_mon.ea || out_b !== e_mon.eb) begin
            n_fail++;
            $display("FAIL beat %0d: out_a=%h out_b=%h, expected %h %h",
                     n_recv, out_a, out_b, e_mon.ea, e_mon.eb);
          end
          n_recv++;
          rx_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        for (int k = 0; k < LANES; k++) begin
          bfly(in_mode, int'(in_shift), longint'(in_a[k*DW +: DW]),
               longint'(in_b[k*DW +: DW]), ra_mon, rb_mon);
          e_mon.ea[k*DW +: DW] = DW'(ra_mon);
          e_mon.eb[k*DW +: DW] = DW'(rb_mon);
        end
        q.push_back(e_mon);
        n_sent++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_a     = out_a;
      prev_b     = out_b;
    end
  end

  // Random downstream backpressure when enabled
  always begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint pa, pb;
    logic [BW-1:0] va, vb;
    logic [BW-1:0] sa[5];
    logic [BW-1:0] sb[5];
    int w, stalls, r0, idx;

    // Model pins against hand-computed values
    bfly(FNT_DIF, 6, 5, 3, pa, pb);      check("model DIF 5,3,s6 a'", pa, 8);     check("model DIF 5,3,s6 b'", pb, 128);
    bfly(FNT_DIF, 6, 65536, 1, pa, pb);  check("model DIF 65536,1 a'", pa, 0);    check("model DIF 65536,1 b'", pb, 65409);
    bfly(FNT_DIT, 16, 10, 1, pa, pb);    check("model DIT s16 a'", pa, 9);        check("model DIT s16 b'", pb, 11);
    bfly(FNT_DIT, 31, 0, 2, pa, pb);     check("model DIT s31 a'", pa, 1);        check("model DIT s31 b'", pb, 65536);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_a", longint'(out_a != '0), 0);
    check("reset out_b", longint'(out_b != '0), 0);
    check("reset in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed boundary beats
    directed("DIF 5,3,s6",      FNT_DIF, 6,  5,     3, 8, 128);
    directed("DIF 65536,1,s6",  FNT_DIF, 6,  65536, 1, 0, 65409);
    directed("DIF 1,3,s0",      FNT_DIF, 0,  1,     3, 4, 65535);
    directed("DIT 10,1,s16",    FNT_DIT, 16, 10,    1, 9, 11);
    directed("DIT 0,2,s31",     FNT_DIT, 31, 0,     2, 1, 65536);

    // Stream 10 beats, alternating modes, full throughput
    rx_cyc.delete();
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      rand_bus(va, vb);
      drive((i % 2) == 1, int'($urandom_range(0, 31)), va, vb, w);
      stalls += w - 1;
    end
    drain();
    check("stream input stalls", stalls, 0);
    check("stream beats delivered", rx_cyc.size(), 10);
    if (rx_cyc.size() == 10) check("stream output span", rx_cyc[9] - rx_cyc[0], 9);

    // Backpressure: 6 cycles of out_ready=0 while offering 5 beats
    for (int i = 0; i < 5; i++) rand_bus(sa[i], sb[i]);
    r0 = n_recv;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 5);
      in_mode  = ((idx % 2) == 1);
      in_shift = SW'(7 * idx + 2);
      in_a     = sa[(idx < 5) ? idx : 4];
      in_b     = sb[(idx < 5) ? idx : 4];
      @(negedge clk);
      if (in_valid && in_ready === 1'b1) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("stall accepted beats", idx, 3);
    @(negedge clk);
    check("stall in_ready", in_ready, 0);
    check("stall out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int j = idx; j < 5; j++) drive((j % 2) == 1, 7 * j + 2, sa[j], sb[j], w);
    drain();
    check("stall beats delivered", n_recv - r0, 5);

    // Reset with two beats in flight (stages 3 and 2)
    rand_bus(va, vb); drive(FNT_DIF, 5, va, vb, w);
    rand_bus(va, vb); drive(FNT_DIT, 9, va, vb, w);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset out_a", longint'(out_a != '0), 0);
    check("midreset out_b", longint'(out_b != '0), 0);
    check("midreset in_ready", in_ready, 1);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midreset discarded beats", n_disc, 2);

    // Random sweep with random gaps and backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rand_bus(va, vb);
      drive(logic'($urandom_range(0, 1)), int'($urandom_range(0, 31)), va, vb, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();
    check("all beats accounted", n_recv + n_disc, n_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
